// File: rtl/vga_input_pkg.sv
// vga_input_pkg: shared types and default constants for the VGA board inputs.
// Holds the button conditioner state type and the default parameters.
package vga_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 0;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

endpackage

// File: rtl/sync_chain.sv
// sync_chain: N-flop synchroniser for asynchronous board inputs.
// Ports: clk, rst (async, active-high), d_i raw input, q_o synchronised output.
module sync_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/btn_press_conditioner.sv
// btn_press_conditioner: sync + debounce of an active-low pushbutton,
// emitting one-cycle press events (with optional auto-repeat) and release events.
// Ports: clk, rst (async, active-high), btn_raw_n raw pin (active-low),
// btn_level_n debounced level, press_n/press press events,
// release_evt release pulse, held high while the button is accepted as down.
module btn_press_conditioner
  import vga_input_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_n,
  output logic btn_level_n,
  output logic press_n,
  output logic press,
  output logic release_evt,
  output logic held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit            REP_EN   = (REPEAT_DELAY > 0);
  // First repeat fires at DELAY; later ones wrap DELAY+PERIOD-1 -> DELAY.
  localparam logic [RW-1:0] R_FIRST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_LAST   = RW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] R_RELOAD = RW'(REPEAT_DELAY);

  logic s;

  sync_chain #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_raw_n),
    .q_o (s)
  );

  btn_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [RW-1:0] rcnt_q;
  logic [RW-1:0] rcnt_d;
  logic          level_q;
  logic          press_q;
  logic          rel_q;

  assign cnt_d  = cnt_q + CW'(1);
  assign rcnt_d = rcnt_q + RW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            press_q <= 1'b1;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        PRESSED: begin
          if (s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end else if (REP_EN) begin
            if (rcnt_q == R_FIRST || rcnt_q == R_LAST) begin
              press_q <= 1'b1;
              rcnt_q  <= R_RELOAD;
            end else begin
              rcnt_q <= rcnt_d;
            end
          end
        end
        RELEASE_WAIT: begin
          // Repeat counter is frozen here so bounce time is not counted.
          if (!s) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rel_q   <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
      endcase
    end
  end

  assign btn_level_n = level_q;
  assign press       = press_q;
  assign press_n     = ~press_q;
  assign release_evt = rel_q;
  assign held        = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule
